instr_seq_mem: RTL

- Writable, parametrised instruction memory with a built-in fetch sequencer, for the memory-interface controller.
- Replaces fixed case-ROM instruction stores: the host loads the program at run time.
- After START, the block streams instruction words downstream over valid/ready.
- It consumes wfi and loop control words internally, handling pause/resume and a programmable pass count.

---
 rtl/instr_seq_mem_if.sv | 32 +++
 rtl/instr_seq_mem.sv | 135 +++++++++++++
 2 files changed

// File: rtl/instr_seq_mem_if.sv
// Host/downstream bundle for instr_seq_mem: program write port, run control and
// the instruction stream. Clock and reset are plain ports on the block itself.
interface instr_seq_mem_if #(
   parameter int DATA_WIDTH = 56,
   parameter int ADDR_WIDTH = 6,
   parameter int ITER_WIDTH = 16
);
   logic                  WR_EN;
   logic [ADDR_WIDTH-1:0] WR_ADDR;
   logic [DATA_WIDTH-1:0] WR_DATA;
   logic                  START;
   logic [ITER_WIDTH-1:0] LOOP_ITERS;
   logic                  RESUME;
   logic [DATA_WIDTH-1:0] INSTR_DATA;
   logic                  INSTR_VALID;
   logic                  INSTR_READY;
   logic [ADDR_WIDTH-1:0] PC;
   logic                  BUSY;
   logic                  WFI_WAIT;
   logic                  DONE;
   logic                  WR_ERR;

   modport master (
      output WR_EN, WR_ADDR, WR_DATA, START, LOOP_ITERS, RESUME, INSTR_READY,
      input  INSTR_DATA, INSTR_VALID, PC, BUSY, WFI_WAIT, DONE, WR_ERR
   );

   modport slave (
      input  WR_EN, WR_ADDR, WR_DATA, START, LOOP_ITERS, RESUME, INSTR_READY,
      output INSTR_DATA, INSTR_VALID, PC, BUSY, WFI_WAIT, DONE, WR_ERR
   );
endinterface

// File: rtl/instr_seq_mem.sv
// Host-loadable instruction store with a fetch sequencer: streams program words
// over valid/ready, consuming wfi/loop control words and counting program passes.
module instr_seq_mem #(
   parameter int                  DATA_WIDTH = 56,
   parameter int                  ADDR_WIDTH = 6,
   parameter int                  DEPTH      = 1 << ADDR_WIDTH,
   parameter int                  OPC_LSB    = 4,
   parameter int                  OPC_WIDTH  = 4,
   parameter logic [OPC_WIDTH-1:0] OPC_WFI   = 4'h6,
   parameter logic [OPC_WIDTH-1:0] OPC_LOOP  = 4'h7,
   parameter int                  ITER_WIDTH = 16
) (
   input  logic           CLK,
   input  logic           RESET_N,
   instr_seq_mem_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WFI, S_DRAIN} state_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] pc_q, rd_addr_q, fetch_addr;
   logic [ITER_WIDTH-1:0] iter_q;
   logic                  rd_vld_q;
   logic [DATA_WIDTH-1:0] ent0_q, ent1_q;
   logic [1:0]            cnt_q, occ_eff;
   logic                  done_q, wr_err_q;

   logic [OPC_WIDTH-1:0]  rd_opc;
   logic                  rd_wfi, rd_loop, rd_wrap;
   logic                  push, pop, start_go, resume_go, issue, wr_ok;

   assign rd_opc  = rdata_q[OPC_LSB +: OPC_WIDTH];
   assign rd_wfi  = rd_vld_q && (rd_opc == OPC_WFI);
   assign rd_loop = rd_vld_q && (rd_opc == OPC_LOOP);
   assign rd_wrap = rd_vld_q && !rd_wfi && !rd_loop && (rd_addr_q == LAST_ADDR);
   assign push    = rd_vld_q && !rd_wfi && !rd_loop;
   assign pop     = (cnt_q != 2'd0) && bus.INSTR_READY;

   // Words already committed to the FIFO or in the read pipe, net of this cycle's pop.
   assign occ_eff = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};

   assign start_go  = (state_q == S_IDLE) && bus.START;
   assign resume_go = (state_q == S_WFI) && (cnt_q == 2'd0) && bus.RESUME;
   // A returning control/wrap word suppresses this cycle's fetch, so nothing
   // speculative past it ever enters the pipe.
   assign issue = start_go || resume_go ||
                  ((state_q == S_RUN) && !rd_wfi && !rd_loop && !rd_wrap && (occ_eff < 2'd2));
   assign fetch_addr = start_go ? '0 : pc_q;
   assign wr_ok      = bus.WR_EN && (state_q == S_IDLE);

   // Program store is deliberately not reset so a loaded program survives RESET_N.
   always_ff @(posedge CLK) begin
      if (wr_ok) mem[bus.WR_ADDR] <= bus.WR_DATA;
      if (issue) rdata_q <= mem[fetch_addr];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         rd_addr_q <= '0;
         iter_q    <= '0;
         rd_vld_q  <= 1'b0;
         ent0_q    <= '0;
         ent1_q    <= '0;
         cnt_q     <= 2'd0;
         done_q    <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         wr_err_q <= bus.WR_EN && (state_q != S_IDLE);
         rd_vld_q <= issue;
         if (issue) begin
            rd_addr_q <= fetch_addr;
            pc_q      <= fetch_addr + ADDR_WIDTH'(1);
         end

         case (state_q)
            S_IDLE: if (bus.START) begin
               iter_q  <= bus.LOOP_ITERS;
               state_q <= S_RUN;
            end
            S_RUN: begin
               if (rd_wfi) begin
                  pc_q    <= rd_addr_q + ADDR_WIDTH'(1);
                  state_q <= S_WFI;
               end else if (rd_loop || rd_wrap) begin
                  // iter_q==0 means run forever; it is never decremented to 0.
                  if (iter_q != ITER_WIDTH'(1)) begin
                     pc_q <= '0;
                     if (iter_q != '0) iter_q <= iter_q - ITER_WIDTH'(1);
                  end else begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_WFI:   if (resume_go) state_q <= S_RUN;
            S_DRAIN: if (cnt_q == 2'd0) begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // 2-entry FIFO, ent0_q is the head presented downstream.
         if (push && !pop) begin
            if (cnt_q == 2'd0) ent0_q <= rdata_q;
            else               ent1_q <= rdata_q;
            cnt_q <= cnt_q + 2'd1;
         end else if (pop && !push) begin
            ent0_q <= ent1_q;
            cnt_q  <= cnt_q - 2'd1;
         end else if (pop && push) begin
            if (cnt_q == 2'd1) begin
               ent0_q <= rdata_q;
            end else begin
               ent0_q <= ent1_q;
               ent1_q <= rdata_q;
            end
         end
      end
   end

   assign bus.INSTR_DATA  = ent0_q;
   assign bus.INSTR_VALID = (cnt_q != 2'd0);
   assign bus.PC          = pc_q;
   assign bus.BUSY        = (state_q != S_IDLE);
   assign bus.WFI_WAIT    = (state_q == S_WFI);
   assign bus.DONE        = done_q;
   assign bus.WR_ERR      = wr_err_q;
endmodule
